// File: rtl/cpc_kbd_pkg.sv
// -----------------------------------------------------------------------------
// cpc_kbd_pkg
// Shared definitions for the CPC keyboard matrix:
//   ROWS            - number of rows in the CPC key matrix (10)
//   JOY_*           - joystick bit positions inside the joy bus and matrix row
//   kmap_t          - keymap lookup result {hit, row, bitpos}
//   km()            - helper building a "hit" keymap result
// Optional feature macro used by the top: CPC_KBD_JOY_EN.
// -----------------------------------------------------------------------------
package cpc_kbd_pkg;

   localparam int ROWS     = 10;
   localparam int ROW_W    = 4;
   localparam int COLS     = 8;

   // Joystick bits; each lands on the matrix column of the same index.
   localparam int JOY_UP    = 0;
   localparam int JOY_DOWN  = 1;
   localparam int JOY_LEFT  = 2;
   localparam int JOY_RIGHT = 3;
   localparam int JOY_FIRE1 = 4;
   localparam int JOY_FIRE2 = 5;
   localparam int JOY_BITS  = 6;

   typedef struct packed {
      logic             hit;
      logic [ROW_W-1:0] row;
      logic [2:0]       bitpos;
   } kmap_t;

   localparam kmap_t KMAP_NONE = '{hit: 1'b0, row: '0, bitpos: '0};

   function automatic kmap_t km(input logic [ROW_W-1:0] r, input logic [2:0] b);
      kmap_t m;
      m.hit    = 1'b1;
      m.row    = r;
      m.bitpos = b;
      return m;
   endfunction

endpackage

// File: rtl/cpc_kbd_matrix_if.sv
// -----------------------------------------------------------------------------
// cpc_kbd_matrix_if
// Bus between the system (PS/2 front end, PPI, PSG, joystick) and the
// keyboard matrix.
//   ps2_key[10:0] - {toggle, pressed, extended, set-2 scancode}
//   row[3:0]      - keyboard row select (PPI port C bits 3:0)
//   joy[5:0]      - {fire2, fire1, right, left, down, up}, active-high
//   col_n[7:0]    - column data for the selected row, active-low
// Modports: master = system side, slave = keyboard matrix.
// -----------------------------------------------------------------------------
interface cpc_kbd_matrix_if;

   logic [10:0] ps2_key;
   logic [3:0]  row;
   logic [5:0]  joy;
   logic [7:0]  col_n;

   modport master (
      output ps2_key,
      output row,
      output joy,
      input  col_n
   );

   modport slave (
      input  ps2_key,
      input  row,
      input  joy,
      output col_n
   );

endinterface

// File: rtl/cpc_keymap.sv
// -----------------------------------------------------------------------------
// cpc_keymap
// Purely combinational translation of a PS/2 set-2 scancode to a CPC key
// matrix position.
//   ext_i       - extended (E0-prefixed) code flag
//   code_i[7:0] - set-2 scancode
//   map_o       - {hit, row, bitpos}; hit=0 for codes with no CPC key
// Several PC keys may share one CPC key (both shifts, both ctrls, ...).
// -----------------------------------------------------------------------------
module cpc_keymap
   import cpc_kbd_pkg::*;
(
   input  logic       ext_i,
   input  logic [7:0] code_i,
   output kmap_t      map_o
);

   always_comb begin
      map_o = KMAP_NONE;
      case ({ext_i, code_i})
         // row 0: cursors and keypad
         9'h175: map_o = km(4'd0, 3'd0);   // cursor up
         9'h174: map_o = km(4'd0, 3'd1);   // cursor right
         9'h172: map_o = km(4'd0, 3'd2);   // cursor down
         9'h07D: map_o = km(4'd0, 3'd3);   // kp9 -> f9
         9'h001: map_o = km(4'd0, 3'd3);   // F9
         9'h074: map_o = km(4'd0, 3'd4);   // kp6 -> f6
         9'h00B: map_o = km(4'd0, 3'd4);   // F6
         9'h07A: map_o = km(4'd0, 3'd5);   // kp3 -> f3
         9'h004: map_o = km(4'd0, 3'd5);   // F3
         9'h15A: map_o = km(4'd0, 3'd6);   // keypad enter
         9'h071: map_o = km(4'd0, 3'd7);   // kp. -> f.
         // row 1
         9'h16B: map_o = km(4'd1, 3'd0);   // cursor left
         9'h011: map_o = km(4'd1, 3'd1);   // left alt -> copy
         9'h111: map_o = km(4'd1, 3'd1);   // right alt -> copy
         9'h06C: map_o = km(4'd1, 3'd2);   // kp7 -> f7
         9'h083: map_o = km(4'd1, 3'd2);   // F7
         9'h075: map_o = km(4'd1, 3'd3);   // kp8 -> f8 (not cursor up: no E0)
         9'h00A: map_o = km(4'd1, 3'd3);   // F8
         9'h073: map_o = km(4'd1, 3'd4);   // kp5 -> f5
         9'h003: map_o = km(4'd1, 3'd4);   // F5
         9'h069: map_o = km(4'd1, 3'd5);   // kp1 -> f1
         9'h005: map_o = km(4'd1, 3'd5);   // F1
         9'h072: map_o = km(4'd1, 3'd6);   // kp2 -> f2
         9'h006: map_o = km(4'd1, 3'd6);   // F2
         9'h070: map_o = km(4'd1, 3'd7);   // kp0 -> f0
         9'h009: map_o = km(4'd1, 3'd7);   // F10 -> f0
         // row 2
         9'h171: map_o = km(4'd2, 3'd0);   // delete -> clr
         9'h05B: map_o = km(4'd2, 3'd1);   // ] -> [
         9'h05A: map_o = km(4'd2, 3'd2);   // return
         9'h05D: map_o = km(4'd2, 3'd3);   // # -> ]
         9'h06B: map_o = km(4'd2, 3'd4);   // kp4 -> f4
         9'h00C: map_o = km(4'd2, 3'd4);   // F4
         9'h012: map_o = km(4'd2, 3'd5);   // left shift
         9'h059: map_o = km(4'd2, 3'd5);   // right shift
         9'h061: map_o = km(4'd2, 3'd6);   // ISO backslash
         9'h014: map_o = km(4'd2, 3'd7);   // left ctrl
         9'h114: map_o = km(4'd2, 3'd7);   // right ctrl
         // row 3
         9'h055: map_o = km(4'd3, 3'd0);   // = -> ^
         9'h04E: map_o = km(4'd3, 3'd1);   // -
         9'h054: map_o = km(4'd3, 3'd2);   // [ -> @
         9'h04D: map_o = km(4'd3, 3'd3);   // P
         9'h052: map_o = km(4'd3, 3'd4);   // ' -> ;
         9'h04C: map_o = km(4'd3, 3'd5);   // ; -> :
         9'h04A: map_o = km(4'd3, 3'd6);   // /
         9'h049: map_o = km(4'd3, 3'd7);   // .
         // row 4
         9'h045: map_o = km(4'd4, 3'd0);   // 0
         9'h046: map_o = km(4'd4, 3'd1);   // 9
         9'h044: map_o = km(4'd4, 3'd2);   // O
         9'h043: map_o = km(4'd4, 3'd3);   // I
         9'h04B: map_o = km(4'd4, 3'd4);   // L
         9'h042: map_o = km(4'd4, 3'd5);   // K
         9'h03A: map_o = km(4'd4, 3'd6);   // M
         9'h041: map_o = km(4'd4, 3'd7);   // ,
         // row 5
         9'h03E: map_o = km(4'd5, 3'd0);   // 8
         9'h03D: map_o = km(4'd5, 3'd1);   // 7
         9'h03C: map_o = km(4'd5, 3'd2);   // U
         9'h035: map_o = km(4'd5, 3'd3);   // Y
         9'h033: map_o = km(4'd5, 3'd4);   // H
         9'h03B: map_o = km(4'd5, 3'd5);   // J
         9'h031: map_o = km(4'd5, 3'd6);   // N
         9'h029: map_o = km(4'd5, 3'd7);   // space
         // row 6
         9'h036: map_o = km(4'd6, 3'd0);   // 6
         9'h02E: map_o = km(4'd6, 3'd1);   // 5
         9'h02D: map_o = km(4'd6, 3'd2);   // R
         9'h02C: map_o = km(4'd6, 3'd3);   // T
         9'h034: map_o = km(4'd6, 3'd4);   // G
         9'h02B: map_o = km(4'd6, 3'd5);   // F
         9'h032: map_o = km(4'd6, 3'd6);   // B
         9'h02A: map_o = km(4'd6, 3'd7);   // V
         // row 7
         9'h025: map_o = km(4'd7, 3'd0);   // 4
         9'h026: map_o = km(4'd7, 3'd1);   // 3
         9'h024: map_o = km(4'd7, 3'd2);   // E
         9'h01D: map_o = km(4'd7, 3'd3);   // W
         9'h01B: map_o = km(4'd7, 3'd4);   // S
         9'h023: map_o = km(4'd7, 3'd5);   // D
         9'h021: map_o = km(4'd7, 3'd6);   // C
         9'h022: map_o = km(4'd7, 3'd7);   // X
         // row 8
         9'h016: map_o = km(4'd8, 3'd0);   // 1
         9'h01E: map_o = km(4'd8, 3'd1);   // 2
         9'h076: map_o = km(4'd8, 3'd2);   // esc
         9'h015: map_o = km(4'd8, 3'd3);   // Q
         9'h00D: map_o = km(4'd8, 3'd4);   // tab
         9'h01C: map_o = km(4'd8, 3'd5);   // A
         9'h058: map_o = km(4'd8, 3'd6);   // caps lock
         9'h01A: map_o = km(4'd8, 3'd7);   // Z
         // row 9: bits 5:0 belong to joystick 0
         9'h066: map_o = km(4'd9, 3'd7);   // backspace -> del
         default: map_o = KMAP_NONE;
      endcase
   end

endmodule

// File: rtl/cpc_kbd_matrix.sv
// -----------------------------------------------------------------------------
// cpc_kbd_matrix
// Amstrad CPC keyboard matrix fed from a PS/2 key event stream.
//   clk_sys  - system clock, all state changes on its rising edge
//   reset_n  - synchronous active-low reset
//   bus      - cpc_kbd_matrix_if.slave: ps2_key, row, joy in; col_n out
// Parameter JOY_ROW selects the matrix row that joystick 0 is merged into.
// Optional feature: define CPC_KBD_JOY_EN to merge joy into row JOY_ROW;
// without it joy is ignored and every row reads matrix data only.
// -----------------------------------------------------------------------------
module cpc_kbd_matrix
   import cpc_kbd_pkg::*;
#(
   parameter int JOY_ROW = 9
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   cpc_kbd_matrix_if.slave bus
);

   logic                      tog_q;
   logic [ROWS-1:0][COLS-1:0] matrix_q;
   logic [ROWS-1:0][COLS-1:0] matrix_d;
   logic [COLS-1:0]           col_n_q;
   logic [COLS-1:0]           col_n_d;

   kmap_t                     map;
   logic                      evt;
   logic                      pressed;
   logic                      wr_en;
   logic [COLS-1:0]           wr_mask;

   cpc_keymap u_keymap (
      .ext_i  (bus.ps2_key[8]),
      .code_i (bus.ps2_key[7:0]),
      .map_o  (map)
   );

   // A PS/2 event is announced by flipping bit 10.
   assign evt     = bus.ps2_key[10] ^ tog_q;
   assign pressed = bus.ps2_key[9];
   assign wr_en   = evt & map.hit;
   assign wr_mask = COLS'(1) << map.bitpos;

   // Only the addressed bit of the addressed row moves; a press clears it,
   // a release sets it. No counting: repeats and stray releases are no-ops.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign matrix_d[gi] = (wr_en && (map.row == ROW_W'(gi)))
                          ? (pressed ? (matrix_q[gi] & ~wr_mask)
                                     : (matrix_q[gi] |  wr_mask))
                          : matrix_q[gi];
   end

   // Read side uses the current (pre-write) matrix, so a write lands on
   // col_n one cycle after the row would otherwise have shown it.
   always_comb begin
      col_n_d = '1;
      if (bus.row < ROW_W'(ROWS)) begin
         col_n_d = matrix_q[bus.row];
`ifdef CPC_KBD_JOY_EN
         if (bus.row == ROW_W'(JOY_ROW)) begin
            col_n_d[JOY_BITS-1:0] = col_n_d[JOY_BITS-1:0] & ~bus.joy;
         end
`endif
      end
   end

`ifndef CPC_KBD_JOY_EN
   logic unused_joy;
   assign unused_joy = ^bus.joy;
`endif

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         // Shadow follows the live toggle so the first cycle out of reset
         // sees no event; anything arriving during reset is dropped.
         tog_q    <= bus.ps2_key[10];
         matrix_q <= '1;
         col_n_q  <= '1;
      end else begin
         tog_q    <= bus.ps2_key[10];
         matrix_q <= matrix_d;
         col_n_q  <= col_n_d;
      end
   end

   assign bus.col_n = col_n_q;

endmodule
